// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between execute and data_memory: one request at a time,
// misaligned loads split into two word reads, misaligned stores into byte writes.
module lsu_mem_initiator #(
    parameter int READ_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  load_store_type,
    output logic        load_unsigned,
    input  logic [31:0] mem_read_data
);

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and the response is a one-cycle pulse with no backpressure.
    typedef enum logic [2:0] {
        S_IDLE, S_ALIGNED, S_RD_LO, S_RD_HI, S_WAIT, S_ST_BYTE, S_RESP, S_ERR
    } state_t;

    typedef enum logic [1:0] {W_ALIGNED, W_LO, W_HI} wait_t;

    state_t      state, state_n;
    wait_t       wret, wret_n;
    logic        write_q, uns_q;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic [1:0]  idx_q, idx_n;
    logic [31:0] lo_q, lo_n, rdata_q, rdata_n;
    logic [31:0] mem_addr_n, mem_write_data_n;
    logic        mem_read_n, mem_write_n, load_unsigned_n;
    logic [1:0]  load_store_type_n;
    logic        accept;

    assign accept = req_valid && (state == S_IDLE);

    function automatic logic is_misaligned(input logic [31:0] a, input logic [1:0] sz);
        return ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a[1:0] != 2'b00));
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        logic [31:0] s;
        s = w >> {i, 3'b000};
        return s[7:0];
    endfunction

    // Shift the lo/hi pair down by the byte offset, then truncate and extend.
    function automatic logic [31:0] merge(input logic [31:0] lo, input logic [31:0] hi,
                                          input logic [1:0] off, input logic [1:0] sz,
                                          input logic uns);
        logic [63:0] sh;
        logic [31:0] r;
        sh = {hi, lo} >> {off, 3'b000};
        case (sz)
            2'b00:   r = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   r = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: r = sh[31:0];
        endcase
        return r;
    endfunction

    always_comb begin
        state_n           = state;
        wret_n            = wret;
        idx_n             = idx_q;
        lo_n              = lo_q;
        rdata_n           = rdata_q;
        mem_addr_n        = mem_addr;
        mem_write_data_n  = mem_write_data;
        mem_read_n        = 1'b0;
        mem_write_n       = 1'b0;
        load_store_type_n = load_store_type;
        load_unsigned_n   = load_unsigned;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    rdata_n = '0;
                    idx_n   = '0;
                    if (req_size == 2'b11) begin
                        state_n = S_ERR;
                    end else if (!is_misaligned(req_addr, req_size)) begin
                        state_n           = S_ALIGNED;
                        mem_addr_n        = req_addr;
                        load_store_type_n = req_size;
                        load_unsigned_n   = req_unsigned;
                        mem_read_n        = !req_write;
                        mem_write_n       = req_write;
                        if (req_write) mem_write_data_n = req_wdata;
                    end else if (!req_write) begin
                        state_n           = S_RD_LO;
                        mem_addr_n        = {req_addr[31:2], 2'b00};
                        load_store_type_n = 2'b10;
                        load_unsigned_n   = 1'b1;
                        mem_read_n        = 1'b1;
                    end else begin
                        state_n           = S_ST_BYTE;
                        mem_addr_n        = req_addr;
                        mem_write_data_n  = {24'b0, req_wdata[7:0]};
                        load_store_type_n = 2'b00;
                        mem_write_n       = 1'b1;
                    end
                end
            end
            S_ALIGNED: begin
                if (!write_q && (READ_LAT == 1)) begin
                    state_n = S_WAIT;
                    wret_n  = W_ALIGNED;
                end else begin
                    if (!write_q) rdata_n = mem_read_data;
                    state_n = S_RESP;
                end
            end
            S_RD_LO: begin
                if (READ_LAT == 1) begin
                    state_n = S_WAIT;
                    wret_n  = W_LO;
                end else begin
                    lo_n       = mem_read_data;
                    state_n    = S_RD_HI;
                    mem_addr_n = {addr_q[31:2], 2'b00} + 32'd4;
                    mem_read_n = 1'b1;
                end
            end
            S_RD_HI: begin
                if (READ_LAT == 1) begin
                    state_n = S_WAIT;
                    wret_n  = W_HI;
                end else begin
                    rdata_n = merge(lo_q, mem_read_data, addr_q[1:0], size_q, uns_q);
                    state_n = S_RESP;
                end
            end
            S_WAIT: begin
                case (wret)
                    W_ALIGNED: begin
                        rdata_n = mem_read_data;
                        state_n = S_RESP;
                    end
                    W_LO: begin
                        lo_n       = mem_read_data;
                        state_n    = S_RD_HI;
                        mem_addr_n = {addr_q[31:2], 2'b00} + 32'd4;
                        mem_read_n = 1'b1;
                    end
                    default: begin
                        rdata_n = merge(lo_q, mem_read_data, addr_q[1:0], size_q, uns_q);
                        state_n = S_RESP;
                    end
                endcase
            end
            S_ST_BYTE: begin
                if (idx_q == ((size_q == 2'b01) ? 2'd1 : 2'd3)) begin
                    state_n = S_RESP;
                end else begin
                    idx_n            = idx_q + 2'd1;
                    mem_addr_n       = addr_q + {30'b0, idx_n};
                    mem_write_data_n = {24'b0, byte_sel(wdata_q, idx_n)};
                    mem_write_n      = 1'b1;
                end
            end
            S_RESP, S_ERR: state_n = S_IDLE;
            default:       state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            wret            <= W_ALIGNED;
            idx_q           <= '0;
            lo_q            <= '0;
            rdata_q         <= '0;
            mem_addr        <= '0;
            mem_write_data  <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            load_store_type <= '0;
            load_unsigned   <= 1'b0;
            write_q         <= 1'b0;
            uns_q           <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            size_q          <= '0;
        end else begin
            state           <= state_n;
            wret            <= wret_n;
            idx_q           <= idx_n;
            lo_q            <= lo_n;
            rdata_q         <= rdata_n;
            mem_addr        <= mem_addr_n;
            mem_write_data  <= mem_write_data_n;
            mem_read        <= mem_read_n;
            mem_write       <= mem_write_n;
            load_store_type <= load_store_type_n;
            load_unsigned   <= load_unsigned_n;
            if (accept) begin
                write_q <= req_write;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
            end
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP) || (state == S_ERR);
    assign resp_err   = (state == S_ERR);
    assign resp_rdata = (state == S_RESP) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: one instance per READ_LAT value, each attached to a
// byte-array memory; results are checked against a byte-level reference model.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [1:0]  req_size [2];
    logic        req_unsigned [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_write_data [2];
    logic        mem_read [2];
    logic        mem_write [2];
    logic [1:0]  load_store_type [2];
    logic        load_unsigned [2];
    logic [31:0] mem_read_data [2];

    bit   [7:0]  dmem [2][65536];
    bit   [7:0]  ref_mem [2][65536];
    logic [31:0] rd_comb [2];
    logic [31:0] rd_word [2];
    logic [15:0] rd_a [2];
    logic [31:0] rd_q1;
    logic [31:0] last_addr [2];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.READ_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .mem_addr(mem_addr[0]),
        .mem_write_data(mem_write_data[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
        .load_store_type(load_store_type[0]), .load_unsigned(load_unsigned[0]),
        .mem_read_data(mem_read_data[0])
    );

    lsu_mem_initiator #(.READ_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .mem_addr(mem_addr[1]),
        .mem_write_data(mem_write_data[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
        .load_store_type(load_store_type[1]), .load_unsigned(load_unsigned[1]),
        .mem_read_data(mem_read_data[1])
    );

    // data_memory model: little-endian bytes, sized access, extension on read
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            rd_a[d]    = mem_addr[d][15:0];
            rd_word[d] = {dmem[d][rd_a[d] + 16'd3], dmem[d][rd_a[d] + 16'd2],
                          dmem[d][rd_a[d] + 16'd1], dmem[d][rd_a[d]]};
            case (load_store_type[d])
                2'b00:   rd_comb[d] = load_unsigned[d] ? {24'b0, rd_word[d][7:0]}
                                                       : {{24{rd_word[d][7]}}, rd_word[d][7:0]};
                2'b01:   rd_comb[d] = load_unsigned[d] ? {16'b0, rd_word[d][15:0]}
                                                       : {{16{rd_word[d][15]}}, rd_word[d][15:0]};
                default: rd_comb[d] = rd_word[d];
            endcase
        end
    end

    assign mem_read_data[0] = rd_comb[0];
    assign mem_read_data[1] = rd_q1;

    always @(posedge clk) begin
        if (mem_read[1]) rd_q1 <= rd_comb[1];
        for (int d = 0; d < 2; d++) begin
            if (mem_write[d]) begin
                for (int i = 0; i < 4; i++) begin
                    if (i < (load_store_type[d] == 2'b00 ? 1 : load_store_type[d] == 2'b01 ? 2 : 4))
                        dmem[d][16'(mem_addr[d] + 32'(i))] <= mem_write_data[d][8*i +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input int d, input logic [31:0] a,
                                             input logic [1:0] sz, input logic u);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[d][16'(a + 32'(i))];
        if (!u && n == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
        if (!u && n == 2 && v[15]) v[31:16] = 16'hFFFF;
        return v;
    endfunction

    task automatic ref_store(input int d, input logic [31:0] a, input logic [31:0] wd, input int n);
        for (int i = 0; i < n; i++) ref_mem[d][16'(a + 32'(i))] = wd[8*i +: 8];
    endtask

    task automatic run_req(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input logic u, output logic [31:0] rd);
        logic        err, mis, got, got_err, lu_seen;
        logic [31:0] exp_rd, exp_last, got_rd;
        logic [1:0]  exp_type, type_seen;
        int          n, exp_lat, exp_rds, exp_wrs, cyc, rds, wrs, viol;
        err      = (sz == 2'b11);
        n        = err ? 0 : (1 << sz);
        mis      = !err && ((a % n) != 0);
        exp_rd   = 32'd0;
        exp_last = last_addr[d];
        exp_rds  = 0;
        exp_wrs  = 0;
        exp_type = sz;
        if (w && !err) begin
            exp_wrs  = mis ? n : 1;
            exp_last = mis ? a + n - 1 : a;
            if (mis) exp_type = 2'b00;
        end else if (!err) begin
            exp_rds  = mis ? 2 : 1;
            exp_rd   = ref_load(d, a, sz, u);
            exp_last = mis ? (a & ~32'd3) + 32'd4 : a;
            if (mis) exp_type = 2'b10;
        end
        exp_lat = 1 + exp_wrs + exp_rds * (1 + d);

        @(negedge clk);
        req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd;
        req_size[d] = sz; req_unsigned[d] = u; req_valid[d] = 1'b1;
        check($sformatf("ready_idle%0d", d), 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1 req_valid[d] = 1'b0;

        cyc = 0; got = 0; rds = 0; wrs = 0; viol = 0;
        got_rd = 32'd0; got_err = 0; type_seen = 2'b00; lu_seen = 0;
        while (!got && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check($sformatf("ready_busy%0d", d), 32'(req_ready[d]), 32'd0);
            if (mem_read[d] && mem_write[d]) viol++;
            if (mem_read[d]) rds++;
            if (mem_write[d]) wrs++;
            if (mem_read[d] || mem_write[d]) begin
                type_seen = load_store_type[d];
                lu_seen   = load_unsigned[d];
            end
            if (resp_valid[d]) begin
                got     = 1;
                got_rd  = resp_rdata[d];
                got_err = resp_err[d];
            end
        end
        rd = got_rd;
        check($sformatf("resp_seen%0d", d), 32'(got), 32'd1);
        check($sformatf("latency%0d a=%08h sz=%0d w=%0d", d, a, sz, w), 32'(cyc), 32'(exp_lat));
        check($sformatf("rdata%0d a=%08h sz=%0d u=%0d", d, a, sz, u), got_rd, exp_rd);
        check($sformatf("err%0d", d), 32'(got_err), 32'(err));
        check($sformatf("n_reads%0d", d), 32'(rds), 32'(exp_rds));
        check($sformatf("n_writes%0d", d), 32'(wrs), 32'(exp_wrs));
        check($sformatf("strobe_excl%0d", d), 32'(viol), 32'd0);
        if (!err) check($sformatf("lst%0d", d), 32'(type_seen), 32'(exp_type));
        if (!err && !w) check($sformatf("lu%0d", d), 32'(lu_seen), mis ? 32'd1 : 32'(u));

        @(negedge clk);
        check($sformatf("resp_pulse%0d", d), {31'b0, resp_valid[d]}, 32'd0);
        check($sformatf("rdata_idle%0d", d), resp_rdata[d], 32'd0);
        check($sformatf("ready_back%0d", d), 32'(req_ready[d]), 32'd1);
        check($sformatf("addr_hold%0d", d), mem_addr[d], exp_last);
        last_addr[d] = exp_last;

        if (w && !err) begin
            ref_store(d, a, wd, n);
            for (int i = 0; i < n; i++)
                check($sformatf("mem_byte%0d @%08h", d, a + 32'(i)),
                      32'(dmem[d][16'(a + 32'(i))]), 32'(wd[8*i +: 8]));
        end
    endtask

    task automatic directed(input int d);
        logic [31:0] r;
        run_req(d, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, r);
        run_req(d, 0, 32'h10, 32'h0, 2'b10, 0, r);
        check($sformatf("plan_lw10_%0d", d), r, 32'hDEADBEEF);
        run_req(d, 1, 32'h18, 32'h000000AA, 2'b00, 0, r);
        run_req(d, 0, 32'h18, 32'h0, 2'b00, 1, r);
        check($sformatf("plan_lbu18_%0d", d), r, 32'h000000AA);
        run_req(d, 0, 32'h18, 32'h0, 2'b00, 0, r);
        check($sformatf("plan_lb18_%0d", d), r, 32'hFFFFFFAA);
        run_req(d, 1, 32'h14, 32'h11223344, 2'b10, 0, r);
        run_req(d, 0, 32'h12, 32'h0, 2'b10, 0, r);
        check($sformatf("plan_lw12_%0d", d), r, 32'h3344DEAD);
        run_req(d, 0, 32'h11, 32'h0, 2'b01, 0, r);
        check($sformatf("plan_lh11_%0d", d), r, 32'hFFFFADBE);
        run_req(d, 0, 32'h11, 32'h0, 2'b01, 1, r);
        check($sformatf("plan_lhu11_%0d", d), r, 32'h0000ADBE);
        run_req(d, 1, 32'h15, 32'hCAFEBABE, 2'b10, 0, r);
        run_req(d, 0, 32'h14, 32'h0, 2'b10, 0, r);
        check($sformatf("plan_lw14_%0d", d), r, 32'hFEBABE44);
        run_req(d, 0, 32'h10, 32'h0, 2'b11, 0, r);
        check($sformatf("plan_err_%0d", d), r, 32'h0);
        run_req(d, 1, 32'h21, 32'h00008001, 2'b01, 0, r);
        run_req(d, 0, 32'h21, 32'h0, 2'b01, 0, r);
        check($sformatf("plan_lh21_%0d", d), r, 32'hFFFF8001);
        run_req(d, 1, 32'hFFFFFFFC, 32'h55667788, 2'b10, 0, r);
        run_req(d, 1, 32'h00000000, 32'h99AABBCC, 2'b10, 0, r);
        run_req(d, 0, 32'hFFFFFFFE, 32'h0, 2'b10, 0, r);
        check($sformatf("plan_wrap_%0d", d), r, 32'hBBCC5566);
    endtask

    task automatic random_reqs(input int d, input int count);
        logic [31:0] r, a;
        logic [1:0]  sz;
        int          pick;
        for (int k = 0; k < count; k++) begin
            pick = $urandom_range(0, 9);
            sz   = (pick == 0) ? 2'b11 : 2'(pick % 3);
            a    = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + $urandom_range(0, 7)
                                               : 32'h100 + $urandom_range(0, 63);
            run_req(d, 1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)), r);
        end
    endtask

    task automatic reset_abort();
        logic [31:0] r;
        int          stray;
        @(negedge clk);
        req_write[0] = 1; req_addr[0] = 32'h25; req_wdata[0] = 32'hCAFEBABE;
        req_size[0] = 2'b10; req_unsigned[0] = 0; req_valid[0] = 1;
        @(posedge clk);
        #1 req_valid[0] = 0;
        repeat (3) @(negedge clk);
        check("abort_pre_write", 32'(mem_write[0]), 32'd1);
        #1 rst[0] = 1;
        #1;
        check("abort_write_drop", 32'(mem_write[0]), 32'd0);
        check("abort_no_resp", 32'(resp_valid[0]), 32'd0);
        check("abort_ready", 32'(req_ready[0]), 32'd1);
        check("abort_addr", mem_addr[0], 32'd0);
        @(negedge clk);
        rst[0] = 0;
        last_addr[0] = 32'd0;
        ref_store(0, 32'h25, 32'h0000BABE, 2);
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid[0] || mem_write[0]) stray++;
        end
        check("abort_quiet", 32'(stray), 32'd0);
        check("abort_ready_after", 32'(req_ready[0]), 32'd1);
        run_req(0, 0, 32'h24, 32'h0, 2'b10, 0, r);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1; req_valid[d] = 0; req_write[d] = 0; req_addr[d] = 0;
            req_wdata[d] = 0; req_size[d] = 0; req_unsigned[d] = 0; last_addr[d] = 0;
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ready%0d", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("rst_resp%0d", d), {30'b0, resp_valid[d], resp_err[d]}, 32'd0);
            check($sformatf("rst_strobes%0d", d), {30'b0, mem_read[d], mem_write[d]}, 32'd0);
            check($sformatf("rst_addr%0d", d), mem_addr[d], 32'd0);
            check($sformatf("rst_rdata%0d", d), resp_rdata[d], 32'd0);
        end
        repeat (3) @(negedge clk);
        rst[0] = 0;
        rst[1] = 0;
        for (int d = 0; d < 2; d++) directed(d);
        for (int d = 0; d < 2; d++) random_reqs(d, 120);
        reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
